// File: rtl/lint_field_framer.sv
// Byte-stream framer: decodes two-byte records into field outputs, buffers them and releases at a fixed pace.
// Optional parity checking on byte1[3] is enabled by defining LINT_FRAMER_PARITY_EN.
module lint_field_framer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PACE  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_byte,
  output logic                       in_ready,
  output logic [1:0]                 Data_in1,
  output logic [2:0]                 Data_in2,
  output logic [3:0]                 Data_in3,
  output logic                       check,
  output logic                       rec_strobe,
  output logic                       err_sync,
  output logic                       err_parity,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (PACE > 1) ? $clog2(PACE) : 1;

  typedef enum logic {IDLE, HDR} state_t;

  typedef struct packed {
    logic [1:0] d1;
    logic       chk;
    logic [3:0] d3;
    logic [2:0] d2;
  } rec_t;

  state_t          state;
  logic [6:0]      byte0;
  rec_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   pace_cnt;
  logic            accept;
  logic            is_start;
  logic            parity_ok;
  logic            push;
  logic            pop;
  logic            pace_done;
  logic [LW-1:0]   level_nxt;
  rec_t            head;

  assign accept   = in_valid & in_ready;
  assign is_start = in_byte[7];

`ifdef LINT_FRAMER_PARITY_EN
  // Even parity over the ten data bits plus the parity bit.
  assign parity_ok = ~(^{byte0, in_byte[3:0]});
`else
  assign parity_ok = 1'b1;
  assign err_parity = 1'b0;
`endif

  assign push      = accept & (state == HDR) & ~is_start & parity_ok;
  assign pace_done = (pace_cnt == CW'(PACE - 1));
  assign pop       = pace_done & (fifo_level != '0);
  assign level_nxt = fifo_level + LW'(push) - LW'(pop);
  assign head      = mem[rd_ptr];

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{d1: byte0[6:5], chk: byte0[4], d3: byte0[3:0], d2: in_byte[2:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte0      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      in_ready   <= 1'b1;
      pace_cnt   <= CW'(PACE - 1);
      Data_in1   <= '0;
      Data_in2   <= '0;
      Data_in3   <= '0;
      check      <= 1'b0;
      rec_strobe <= 1'b0;
      err_sync   <= 1'b0;
`ifdef LINT_FRAMER_PARITY_EN
      err_parity <= 1'b0;
`endif
    end else begin
      rec_strobe <= 1'b0;
      err_sync   <= 1'b0;
`ifdef LINT_FRAMER_PARITY_EN
      err_parity <= 1'b0;
`endif
      // Frame decode
      if (accept) begin
        case (state)
          IDLE: begin
            if (is_start) begin
              byte0 <= in_byte[6:0];
              state <= HDR;
            end else begin
              err_sync <= 1'b1;
            end
          end
          HDR: begin
            if (is_start) begin
              err_sync <= 1'b1;
              byte0    <= in_byte[6:0];
            end else begin
              state <= IDLE;
`ifdef LINT_FRAMER_PARITY_EN
              if (!parity_ok) err_parity <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Paced release of the FIFO head onto the field outputs
      if (pop) begin
        pace_cnt   <= '0;
        rd_ptr     <= rd_ptr + AW'(1);
        Data_in1   <= head.d1;
        check      <= head.chk;
        Data_in3   <= head.d3;
        Data_in2   <= head.d2;
        rec_strobe <= 1'b1;
      end else if (!pace_done) begin
        pace_cnt <= pace_cnt + CW'(1);
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      fifo_level <= level_nxt;
      in_ready   <= (level_nxt != LW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_lint_field_framer.sv
// Directed self-checking bench for lint_field_framer (DEPTH=4, PACE=4).
module tb_lint_field_framer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PACE  = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  // Expected released records packed as {Data_in1, check, Data_in3, Data_in2}
  localparam logic [9:0] R1 = 10'b01_1_1010_110;  // 0xBA 0x06
  localparam logic [9:0] R2 = 10'b00_0_0101_110;  // 0x85 0x06
  localparam logic [9:0] R3 = 10'b10_0_0000_001;  // 0xC0 0x01
  localparam logic [9:0] R4 = 10'b11_1_1111_111;  // 0xFF 0x07
  localparam logic [9:0] R5 = 10'b00_1_0001_010;  // 0x91 0x0A

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready;
  logic [1:0]    Data_in1;
  logic [2:0]    Data_in2;
  logic [3:0]    Data_in3;
  logic          rec_check;
  logic          rec_strobe;
  logic          err_sync;
  logic          err_parity;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sync_n = 0;
  int par_n  = 0;
  bit saw_full = 1'b0;
  logic [9:0] rec_q[$];
  int         stamp_q[$];

  logic [7:0] b0_tab [5] = '{8'hBA, 8'h85, 8'hC0, 8'hFF, 8'h91};
  logic [7:0] b1_tab [5] = '{8'h06, 8'h06, 8'h01, 8'h07, 8'h0A};
  logic [9:0] exp_tab[5] = '{R1, R2, R3, R4, R5};

  lint_field_framer #(.DEPTH(DEPTH), .PACE(PACE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .Data_in1   (Data_in1),
    .Data_in2   (Data_in2),
    .Data_in3   (Data_in3),
    .check      (rec_check),
    .rec_strobe (rec_strobe),
    .err_sync   (err_sync),
    .err_parity (err_parity),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] outs();
    return {Data_in1, rec_check, Data_in3, Data_in2};
  endfunction

  // Event monitor; in_ready must mirror "not full" every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (rec_strobe) begin
        rec_q.push_back(outs());
        stamp_q.push_back(cyc);
      end
      if (err_sync)   sync_n++;
      if (err_parity) par_n++;
      if (fifo_level == LW'(DEPTH)) saw_full = 1'b1;
      check_val("in_ready_vs_level", 32'(in_ready), 32'(fifo_level != LW'(DEPTH)));
    end
  end

  task automatic clear_mon();
    rec_q.delete();
    stamp_q.delete();
    sync_n = 0;
    par_n  = 0;
    saw_full = 1'b0;
  endtask

  // Present one byte at a negedge and return at the negedge after it is accepted.
  task automatic send(input logic [7:0] b);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int n = 0; n < 64 && !done; n++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    check_val("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_fields", 32'(outs()), 32'd0);
    check_val("rst_level", 32'(fifo_level), 32'd0);
    check_val("rst_pulses", 32'({rec_strobe, err_sync, err_parity}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single record: release one edge after the push, counter already saturated
    in_valid = 1'b1;
    in_byte  = 8'hBA;
    @(negedge clk);
    in_byte  = 8'h06;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("t1_level_after_push", 32'(fifo_level), 32'd1);
    check_val("t1_no_early_strobe", 32'(rec_strobe), 32'd0);
    @(negedge clk);
    check_val("t1_strobe", 32'(rec_strobe), 32'd1);
    check_val("t1_fields", 32'(outs()), 32'(R1));
    check_val("t1_level_after_pop", 32'(fifo_level), 32'd0);
    @(negedge clk);
    check_val("t1_strobe_one_cycle", 32'(rec_strobe), 32'd0);
    check_val("t1_hold", 32'(outs()), 32'(R1));
    idle(6);

    // Back-to-back records until the FIFO fills; pacing keeps releases 4 apart
    clear_mon();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 5; i++) begin
        send(b0_tab[i]);
        send(b1_tab[i]);
      end
    end
    idle(60);
    check_val("t2_count", 32'(rec_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < rec_q.size(); i++)
      check_val($sformatf("t2_rec%0d", i), 32'(rec_q[i]), 32'(exp_tab[i % 5]));
    for (int i = 1; i < stamp_q.size(); i++)
      check_val($sformatf("t2_gap%0d", i), 32'(stamp_q[i] - stamp_q[i-1]), 32'(PACE));
    check_val("t2_saw_full", 32'(saw_full), 32'd1);
    check_val("t2_drained", 32'(fifo_level), 32'd0);

    // Parity bit flipped
    clear_mon();
    send(8'hBA);
    send(8'h0E);
    idle(10);
`ifdef LINT_FRAMER_PARITY_EN
    check_val("t3_err_parity", 32'(par_n), 32'd1);
    check_val("t3_no_release", 32'(rec_q.size()), 32'd0);
    check_val("t3_hold", 32'(outs()), 32'(R5));
`else
    check_val("t3_err_parity", 32'(par_n), 32'd0);
    check_val("t3_release", 32'(rec_q.size()), 32'd1);
    check_val("t3_fields", 32'(rec_q.size() > 0 ? rec_q[0] : 10'h3FF), 32'(R1));
`endif

    // Start byte arriving in HDR resyncs onto the new record
    clear_mon();
    send(8'hBA);
    send(8'h85);
    send(8'h06);
    idle(10);
    check_val("t4_err_sync", 32'(sync_n), 32'd1);
    check_val("t4_release", 32'(rec_q.size()), 32'd1);
    check_val("t4_fields", 32'(rec_q.size() > 0 ? rec_q[0] : 10'h3FF), 32'(R2));

    // Stray continuation byte in IDLE
    clear_mon();
    send(8'h06);
    idle(10);
    check_val("t5_err_sync", 32'(sync_n), 32'd1);
    check_val("t5_no_release", 32'(rec_q.size()), 32'd0);
    check_val("t5_level", 32'(fifo_level), 32'd0);
    check_val("t5_hold", 32'(outs()), 32'(R2));

    // Reset mid-record discards the latched start byte
    clear_mon();
    send(8'hBA);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t6_rst_fields", 32'(outs()), 32'd0);
    check_val("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("t6_rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h06);
    idle(10);
    check_val("t6_err_sync", 32'(sync_n), 32'd1);
    check_val("t6_no_release", 32'(rec_q.size()), 32'd0);
    check_val("t6_fields_zero", 32'(outs()), 32'd0);
    check_val("t6_no_parity_err", 32'(par_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
